// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// Module  : keypad_pkg
// Purpose : Shared definitions for the 4x4 keypad entry block: FSM state
//           encoding, key codes, the row/column keymap and a row-priority
//           helper.
// Ports   : (package, no ports)
// Rev     : 1.0  initial release
// ============================================================================
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    ACT      = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  // Digits 0..9 are encoded as themselves; function keys follow.
  localparam logic [3:0] KEY_A    = 4'd10;
  localparam logic [3:0] KEY_B    = 4'd11;
  localparam logic [3:0] KEY_C    = 4'd12;
  localparam logic [3:0] KEY_D    = 4'd13;
  localparam logic [3:0] KEY_STAR = 4'd14;
  localparam logic [3:0] KEY_HASH = 4'd15;

  localparam logic [2:0] MAX_DIGITS = 3'd4;

  // KEYMAP[row][col]. Leftmost concatenation element is row 3 / column 3.
  localparam logic [3:0][3:0][3:0] KEYMAP = {
    {KEY_D, KEY_HASH, 4'd0, KEY_STAR},  // row 3: * 0 # D
    {KEY_C, 4'd9,     4'd8, 4'd7    },  // row 2: 7 8 9 C
    {KEY_B, 4'd6,     4'd5, 4'd4    },  // row 1: 4 5 6 B
    {KEY_A, 4'd3,     4'd2, 4'd1    }   // row 0: 1 2 3 A
  };

  // Lowest-index active-low row; only called when at least one row is low.
  function automatic logic [1:0] lowest_low(input logic [3:0] r);
    if (!r[0])      return 2'd0;
    else if (!r[1]) return 2'd1;
    else if (!r[2]) return 2'd2;
    else            return 2'd3;
  endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_decode.sv
`default_nettype none
// ============================================================================
// Module  : keypad_decode
// Purpose : Combinational lookup of the key code at a (column, row) position.
// Ports   : col  [1:0] in  - latched scan column
//           row  [1:0] in  - latched active row
//           key  [3:0] out - key code (0..9 digits, 10..15 function keys)
// Rev     : 1.0  initial release
// ============================================================================
module keypad_decode
  import keypad_pkg::*;
(
  input  logic [1:0] col,
  input  logic [1:0] row,
  output logic [3:0] key
);

  assign key = KEYMAP[row][col];

endmodule
`default_nettype wire

// File: rtl/keypad_entry.sv
`default_nettype none
// ============================================================================
// Module  : keypad_entry
// Purpose : Scans a 4x4 active-low keypad, debounces presses and releases,
//           and accumulates up to four decimal digits with backspace, clear
//           and enter keys.
// Ports   : scan_clk        in   - sole clock
//           rst_n           in   - async assert, active-low reset
//           rows      [3:0] in   - keypad rows, active-low, asynchronous
//           cols      [3:0] out  - column drive, active-low one-hot
//           entry    [15:0] out  - live accumulated value 0..9999
//           digit_cnt [2:0] out  - digits accumulated 0..4
//           dout     [15:0] out  - last committed value
//           dout_valid      out  - one-cycle pulse when dout updates
// Rev     : 1.0  initial release
// ============================================================================
module keypad_entry
  import keypad_pkg::*;
#(
  parameter int DWELL          = 4,
  parameter int DEBOUNCE_TICKS = 8
) (
  input  logic        scan_clk,
  input  logic        rst_n,
  input  logic [3:0]  rows,
  output logic [3:0]  cols,
  output logic [15:0] entry,
  output logic [2:0]  digit_cnt,
  output logic [15:0] dout,
  output logic        dout_valid
);

  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);
  localparam logic [7:0] TICKS      = 8'(DEBOUNCE_TICKS);

  state_t      state, state_nx;
  logic [3:0]  sync1, rs;
  logic [1:0]  col, col_nx;
  logic [1:0]  row, row_nx;
  logic [7:0]  dwell_cnt, dwell_nx;
  logic [7:0]  deb_cnt, deb_nx;
  logic [15:0] entry_nx, dout_nx;
  logic [2:0]  digit_nx;
  logic        valid_nx;
  logic [3:0]  key;

  keypad_decode u_decode (
    .col (col),
    .row (row),
    .key (key)
  );

  assign cols = ~(4'b0001 << col);

  // Two-flop synchronizer; idle value is all rows released.
  always_ff @(posedge scan_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 4'hF;
      rs    <= 4'hF;
    end else begin
      sync1 <= rows;
      rs    <= sync1;
    end
  end

  always_ff @(posedge scan_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= SCAN;
      col        <= '0;
      row        <= '0;
      dwell_cnt  <= '0;
      deb_cnt    <= '0;
      entry      <= '0;
      digit_cnt  <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      state      <= state_nx;
      col        <= col_nx;
      row        <= row_nx;
      dwell_cnt  <= dwell_nx;
      deb_cnt    <= deb_nx;
      entry      <= entry_nx;
      digit_cnt  <= digit_nx;
      dout       <= dout_nx;
      dout_valid <= valid_nx;
    end
  end

  always_comb begin
    state_nx = state;
    col_nx   = col;
    row_nx   = row;
    dwell_nx = dwell_cnt;
    deb_nx   = deb_cnt;
    entry_nx = entry;
    digit_nx = digit_cnt;
    dout_nx  = dout;
    valid_nx = 1'b0;

    case (state)
      SCAN: begin
        // Rows are only trusted on the last dwell cycle, once the
        // synchronizer has caught up with the newly driven column.
        if (dwell_cnt == DWELL_LAST) begin
          dwell_nx = '0;
          if (rs == 4'hF) begin
            col_nx = col + 2'd1;
          end else begin
            row_nx   = lowest_low(rs);
            deb_nx   = '0;
            state_nx = DEBOUNCE;
          end
        end else begin
          dwell_nx = dwell_cnt + 8'd1;
        end
      end

      DEBOUNCE: begin
        if (!rs[row]) begin
          if (deb_cnt + 8'd1 == TICKS) begin
            deb_nx   = '0;
            state_nx = ACT;
          end else begin
            deb_nx = deb_cnt + 8'd1;
          end
        end else begin
          // Glitch: abandon and move on rather than re-testing this column.
          deb_nx   = '0;
          dwell_nx = '0;
          col_nx   = col + 2'd1;
          state_nx = SCAN;
        end
      end

      ACT: begin
        deb_nx   = '0;
        state_nx = RELEASE;
        if (key <= 4'd9) begin
          if (digit_cnt < MAX_DIGITS) begin
            // 17-bit product; at most 999*10+9, so the cast never truncates.
            entry_nx = 16'({1'b0, entry} * 17'd10 + {13'd0, key});
            digit_nx = digit_cnt + 3'd1;
          end
        end else if (key == KEY_A) begin
          if (digit_cnt != 3'd0) begin
            entry_nx = entry / 16'd10;
            digit_nx = digit_cnt - 3'd1;
          end
        end else if (key == KEY_STAR) begin
          entry_nx = '0;
          digit_nx = '0;
        end else if (key == KEY_HASH) begin
          if (digit_cnt != 3'd0) begin
            dout_nx  = entry;
            valid_nx = 1'b1;
            entry_nx = '0;
            digit_nx = '0;
          end
        end
      end

      RELEASE: begin
        if (rs[row]) begin
          if (deb_cnt + 8'd1 == TICKS) begin
            deb_nx   = '0;
            dwell_nx = '0;
            col_nx   = col + 2'd1;
            state_nx = SCAN;
          end else begin
            deb_nx = deb_cnt + 8'd1;
          end
        end else begin
          deb_nx = '0;
        end
      end

      default: state_nx = SCAN;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_keypad_entry.sv
`default_nettype none
// ============================================================================
// Module  : tb_keypad_entry
// Purpose : Self-checking bench for keypad_entry: a keypad matrix model
//           drives rows from cols, a key-level behavioural model predicts
//           entry/digit_cnt/dout, and a per-cycle monitor compares.
// Rev     : 1.0  initial release
// ============================================================================
module tb_keypad_entry;

  localparam int DWELL = 4;
  localparam int TICKS = 8;

  logic        scan_clk = 1'b0;
  logic        rst_n;
  logic [3:0]  rows;
  logic [3:0]  cols;
  logic [15:0] entry;
  logic [2:0]  digit_cnt;
  logic [15:0] dout;
  logic        dout_valid;

  logic [15:0] down;   // pressed switches, bit index r*4+c

  int vectors = 0;
  int fails   = 0;

  // Settled expectation, and the candidate after the key in progress.
  int exp_e = 0, exp_c = 0, exp_d = 0;
  int new_e = 0, new_c = 0, new_d = 0;
  bit win = 1'b0, seen_new = 1'b0;
  int exp_pulse = 0, pulses = 0;

  int km [4][4] = '{'{1, 2, 3, 10}, '{4, 5, 6, 11}, '{7, 8, 9, 12}, '{14, 0, 15, 13}};

  always #5 scan_clk = ~scan_clk;

  keypad_entry #(.DWELL(DWELL), .DEBOUNCE_TICKS(TICKS)) dut (
    .scan_clk   (scan_clk),
    .rst_n      (rst_n),
    .rows       (rows),
    .cols       (cols),
    .entry      (entry),
    .digit_cnt  (digit_cnt),
    .dout       (dout),
    .dout_valid (dout_valid)
  );

  // Switch matrix: a pressed key shorts its row to its column.
  always_comb begin
    rows = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (down[r*4+c] && !cols[c]) rows[r] = 1'b0;
  end

  function automatic void chk(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endfunction

  // Per-cycle monitor, half a cycle away from the active edge.
  always @(negedge scan_clk) begin
    bit is_new, is_old;
    if (!rst_n) begin
      chk("rst_cols", int'(cols), 14);
      chk("rst_entry", int'(entry), 0);
      chk("rst_digit_cnt", int'(digit_cnt), 0);
      chk("rst_dout", int'(dout), 0);
      chk("rst_dout_valid", int'(dout_valid), 0);
    end else begin
      chk("cols_onehot_low", $countones(~cols), 1);
      if (win) begin
        is_new = (int'(entry) == new_e) && (int'(digit_cnt) == new_c) && (int'(dout) == new_d);
        is_old = (int'(entry) == exp_e) && (int'(digit_cnt) == exp_c) && (int'(dout) == exp_d);
        if (is_new) seen_new = 1'b1;
        vectors++;
        if (!(is_new || (is_old && !seen_new))) begin
          fails++;
          $display("FAIL transition: got entry=%0d cnt=%0d dout=%0d, expected old %0d/%0d/%0d or new %0d/%0d/%0d at %0t",
                   entry, digit_cnt, dout, exp_e, exp_c, exp_d, new_e, new_c, new_d, $time);
        end
        if (dout_valid) begin
          pulses++;
          chk("pulse_allowed", exp_pulse, 1);
          chk("pulse_dout", int'(dout), new_d);
        end
      end else begin
        chk("entry", int'(entry), exp_e);
        chk("digit_cnt", int'(digit_cnt), exp_c);
        chk("dout", int'(dout), exp_d);
        chk("dout_valid_idle", int'(dout_valid), 0);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge scan_clk);
      #2;
    end
  endtask

  task automatic find(input int k, output int r, output int c);
    r = 0;
    c = 0;
    for (int rr = 0; rr < 4; rr++)
      for (int cc = 0; cc < 4; cc++)
        if (km[rr][cc] == k) begin
          r = rr;
          c = cc;
        end
  endtask

  // Press key k (optionally together with k2 in a higher row of the same
  // column), hold, release, and let the model predict the one action of k.
  task automatic press2(input int k, input int k2, input int hold, input int bounce);
    int r, c, r2, c2, i1, i2;
    int e, n, d, p;
    find(k, r, c);
    i1 = r * 4 + c;
    i2 = i1;
    if (k2 >= 0) begin
      find(k2, r2, c2);
      i2 = r2 * 4 + c2;
    end
    e = exp_e; n = exp_c; d = exp_d; p = 0;
    if (k <= 9) begin
      if (n < 4) begin e = e * 10 + k; n = n + 1; end
    end else if (k == 10) begin
      if (n > 0) begin e = e / 10; n = n - 1; end
    end else if (k == 14) begin
      e = 0; n = 0;
    end else if (k == 15) begin
      if (n > 0) begin d = e; p = 1; e = 0; n = 0; end
    end
    new_e = e; new_c = n; new_d = d; exp_pulse = p;
    seen_new = 1'b0;
    pulses = 0;
    win = 1'b1;
    if (bounce != 0)
      repeat (3) begin
        down[i1] = 1'b1; down[i2] = 1'b1; cyc($urandom_range(1, 2));
        down[i1] = 1'b0; down[i2] = 1'b0; cyc($urandom_range(1, 3));
      end
    down[i1] = 1'b1; down[i2] = 1'b1;
    cyc(hold);
    if (bounce != 0)
      repeat (3) begin
        down[i1] = 1'b0; down[i2] = 1'b0; cyc($urandom_range(1, 3));
        down[i1] = 1'b1; down[i2] = 1'b1; cyc($urandom_range(1, 2));
      end
    down[i1] = 1'b0; down[i2] = 1'b0;
    cyc(60);
    chk("pulse_count", pulses, exp_pulse);
    exp_e = new_e; exp_c = new_c; exp_d = new_d;
    win = 1'b0;
  endtask

  task automatic press(input int k);
    press2(k, -1, 70, 0);
  endtask

  task automatic wait_col(input logic [3:0] pat, input string name);
    int g;
    g = 0;
    while (cols == pat && g < 100) begin cyc(1); g++; end
    while (cols != pat && g < 200) begin cyc(1); g++; end
    chk(name, int'(cols), int'(pat));
  endtask

  initial begin
    int len, k;
    rst_n = 1'b0;
    down  = '0;
    cyc(4);
    rst_n = 1'b1;
    cyc(5);

    // Digit entry and commit.
    press(1);  chk("lit_entry_1", int'(entry), 1);
    press(2);  chk("lit_entry_12", int'(entry), 12);
    press(3);  chk("lit_entry_123", int'(entry), 123);
    press(4);  chk("lit_entry_1234", int'(entry), 1234);
    press(15);
    chk("lit_dout_1234", int'(dout), 1234);
    chk("lit_entry_after_enter", int'(entry), 0);
    chk("lit_cnt_after_enter", int'(digit_cnt), 0);

    // Fifth digit ignored, then backspace.
    press(9); press(8); press(7); press(6); press(5);
    chk("lit_entry_9876", int'(entry), 9876);
    chk("lit_cnt_4", int'(digit_cnt), 4);
    press(10);
    chk("lit_entry_987", int'(entry), 987);
    chk("lit_cnt_3", int'(digit_cnt), 3);

    // Short row glitch while column 1 is driven.
    cyc(30);
    wait_col(4'b1101, "glitch_find_col1");
    down[1] = 1'b1;
    len = 1;
    for (int i = 1; i < 40; i++) begin
      cyc(1);
      if (i == 3) down[1] = 1'b0;
      if (cols != 4'b1101) break;
      len++;
    end
    chk("glitch_col1_cycles", len, DWELL + 2);
    chk("glitch_next_col", int'(cols), 4'b1011);
    cyc(40);

    // Long hold with release bounce: one append only.
    press(14);
    press2(5, -1, 500, 1);
    chk("lit_hold_entry_5", int'(entry), 5);
    chk("lit_hold_cnt_1", int'(digit_cnt), 1);

    // Enter with nothing accumulated, clear after 42.
    press(14);
    press(15);
    chk("lit_dout_kept", int'(dout), 1234);
    press(4); press(2);
    chk("lit_entry_42", int'(entry), 42);
    press(14);
    chk("lit_clear_entry", int'(entry), 0);
    chk("lit_clear_dout", int'(dout), 1234);

    // Two keys in one column: the lower row wins.
    press2(1, 4, 80, 0);
    chk("lit_multi_entry", int'(entry), 1);

    // Randomized key sequences with random hold and bounce.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) k = int'($urandom_range(10, 15));
      else                           k = int'($urandom_range(0, 9));
      press2(k, -1, int'($urandom_range(60, 150)), int'($urandom_range(0, 1)));
    end

    // Reset in the middle of debouncing key 7.
    press(14);
    press(4); press(2);
    cyc(20);
    wait_col(4'b1110, "rst_find_col0");
    down[8] = 1'b1;
    cyc(6);
    rst_n = 1'b0;
    exp_e = 0; exp_c = 0; exp_d = 0;
    #1;
    chk("rst_mid_cols", int'(cols), 14);
    chk("rst_mid_entry", int'(entry), 0);
    chk("rst_mid_cnt", int'(digit_cnt), 0);
    chk("rst_mid_dout", int'(dout), 0);
    cyc(3);
    down[8] = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    #1;
    chk("rst_release_cols", int'(cols), 14);
    cyc(100);
    chk("rst_no_append", int'(entry), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
